dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU load/store port (primary) and the UART bootloader/debug loader port (secondary).
- Sits between the Riscv151 memory stage, the serial loader, and the dmem array.
- Provides fixed CPU priority with a starvation bound for the loader.
- Provides a loader lock mode so a program image can be written without CPU interference.

Parameters:
- ADDR_W, 14, word-address width; dmem depth is 2^ADDR_W words.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- STARVE_MAX, 4, cycles a waiting loader request may be denied before it preempts the CPU. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt.
- cpu_we  in  4  CPU byte write enables; 0 means read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/4/ADDR_W/DATA_W  loader request fields; same rules as the CPU fields.
- ldr_lock  in  1  loader requests exclusive ownership.
- ldr_gnt, ldr_rvalid, ldr_rdata  out  1/1/DATA_W  loader grant and read return.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1.
- locked  out  1  state is LOCKED.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = ARB; starve counter = 0; read-owner tag cleared.
  - Outputs: gnt=0, rvalid=0, locked=0.
  - A read pending when reset asserts is dropped; no rvalid is produced after release.
- Grants are combinational from req and registered state. At most one gnt per cycle.
  - mem_en equals cpu_gnt | ldr_gnt.
  - mem_* fields are muxed from the granted requester, and are 0 when neither is granted.
- ARB state, loader preempts when ldr_req=1 and (cpu_req=0 or starve_cnt == STARVE_MAX).
  - Otherwise a requesting CPU is granted.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle ldr_req=1 and ldr_gnt=0.
  - Clears on ldr_gnt, or when ldr_req=0.
- ARB -> LOCKED: on a cycle with ldr_gnt=1 and ldr_lock=1.
- LOCKED:
  - cpu_gnt=0 unconditionally; ldr_gnt = ldr_req.
  - Starve counter held at 0.
- LOCKED -> ARB: the cycle after ldr_lock samples 0. The ldr_lock=0 cycle itself still behaves as LOCKED.
- Read return latency = 1:
  - A granted read (we==0) registers its owner tag.
  - Next cycle the owner's rvalid=1. rdata = mem_rdata is routed to both rdata outputs and qualified only by rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners each return in order, one per cycle.
- Simultaneous cpu_req and ldr_req with starve_cnt < STARVE_MAX: CPU wins.
- STARVE_MAX=1: the loader wins on the second contended cycle.
- Address and byte-enable widths pass through unchanged; no address translation or range checking.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {ARB, LOCKED}.
  - Owner enum {OWN_NONE, OWN_CPU, OWN_LDR}.
  - Constant BE_W = DATA_W/8.
- One natural sub-module: starve_counter (saturating counter with clear, STARVE_MAX limit).
- Arbiter FSM and datapath mux stay in the top.

Test Plan:
- Reset release, no requests -> all gnt/rvalid/mem_en = 0, locked=0. Assert rst=0 mid-read -> no rvalid after release.
- CPU write word addr 5 = 0xDEADBEEF (we=4'hF), then read addr 5 -> cpu_gnt each cycle; cpu_rvalid=1 one cycle after the read grant with cpu_rdata=0xDEADBEEF; ldr_rvalid=0.
- cpu_req held high continuously, ldr_req raised at cycle 0, STARVE_MAX=4 -> CPU granted cycles 0-3, ldr_gnt at cycle 4, CPU regains the grant at cycle 5.
- ldr_lock=1 with writes to addrs 0..7 while cpu_req=1 -> locked=1 from the cycle after the first ldr_gnt; cpu_gnt=0 throughout; drop ldr_lock -> cpu_gnt on the next cycle.
- Alternating reads, CPU addr 1 then loader addr 2 on consecutive cycles -> cpu_rvalid then ldr_rvalid on consecutive cycles with the correct respective data.
- Byte write we=4'b0100, data 0x00AB0000, to a word holding 0x11223344, then read -> 0x11AB3344.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the data-memory arbiter.
//
// Contents:
//   arb_state_e  - arbiter FSM state (ARB = normal priority arbitration,
//                  LOCKED = loader owns the memory exclusively)
//   owner_e      - tag for the requester whose read data returns next cycle
//   DATA_W_DEF   - default data width
//   BE_W         - byte-enable width (DATA_W/8)
//   CNT_W        - starve counter width (covers STARVE_MAX up to 15)
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;

    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating cycle counter with synchronous clear.
//
// Counts how many consecutive cycles the loader has been denied. Once the
// count reaches MAX it holds there and at_max tells the arbiter to let the
// loader preempt the CPU.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   inc     in   count one more denied cycle (ignored at MAX)
//   clr     in   clear to zero (dominates inc)
//   cnt     out  current count
//   at_max  out  cnt == MAX
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the
// CPU load/store port (primary) and the serial loader port (secondary).
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata and holds
// them stable until it sees *_gnt high in the same cycle; the access is
// issued to memory in that cycle. A granted read (we == 0) returns exactly
// one cycle later with *_rvalid high; *_rdata is only meaningful while the
// matching *_rvalid is high. Writes produce no rvalid.
//
// Ports:
//   clk, rst                          clock / asynchronous active-low reset
//   cpu_req/we/addr/wdata             CPU request fields
//   cpu_gnt, cpu_rvalid, cpu_rdata    CPU grant and read return
//   ldr_req/we/addr/wdata, ldr_lock   loader request fields, exclusive-lock
//   ldr_gnt, ldr_rvalid, ldr_rdata    loader grant and read return
//   mem_en/we/addr/wdata, mem_rdata   memory port (1-cycle read latency)
//   locked                            arbiter is in the LOCKED state
//   dbg_state                         current FSM state, for observation
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic [BE_W-1:0]   cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic [BE_W-1:0]   ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              locked,
    output arb_state_e        dbg_state
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_sat;
    logic             starve_inc, starve_clr;

    // ------------------------------------------------------------------
    // Starvation tracking: counts denied loader cycles in ARB only.
    // ------------------------------------------------------------------
    assign starve_inc = ldr_req && !ldr_gnt && (state_q == ARB);
    assign starve_clr = ldr_gnt || !ldr_req || (state_q == LOCKED);

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .cnt    (starve_cnt),
        .at_max (starve_sat)
    );

    // ------------------------------------------------------------------
    // FSM state register and read-owner tag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant and next-state logic. Grants are suppressed while reset is
    // asserted so no access reaches memory during reset.
    // ------------------------------------------------------------------
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        state_d = state_q;
        if (rst) begin
            unique case (state_q)
                ARB: begin
                    // Loader wins when the CPU is idle or it has waited
                    // STARVE_MAX denied cycles; otherwise the CPU has priority.
                    if (ldr_req && (!cpu_req || starve_sat)) begin
                        ldr_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    if (ldr_gnt && ldr_lock) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    ldr_gnt = ldr_req;
                    // The cycle that samples ldr_lock=0 is still LOCKED.
                    if (!ldr_lock) begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // Read-owner tag for the access issued this cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_gnt && (cpu_we == '0)) begin
            owner_d = OWN_CPU;
        end else if (ldr_gnt && (ldr_we == '0)) begin
            owner_d = OWN_LDR;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side mux: fields come from the granted requester, 0 if idle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    assign mem_en = cpu_gnt | ldr_gnt;

    // Read data is shared; the owner tag decides whose rvalid fires.
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign ldr_rvalid = (owner_q == OWN_LDR);
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;

    assign locked    = (state_q == LOCKED);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cpu_req = 1'b0;
  logic [3:0]        cpu_we = '0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ldr_req = 1'b0;
  logic [3:0]        ldr_we = '0;
  logic [ADDR_W-1:0] ldr_addr = '0;
  logic [DATA_W-1:0] ldr_wdata = '0;
  logic              ldr_lock = 1'b0;
  logic              ldr_gnt, ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              locked;
  arb_state_e        dbg_state;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked), .dbg_state(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [DATA_W-1:0] bmem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'h0) mem_rdata <= bmem[mem_addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W:0]   exp_q[$];          // {is_loader, data}
  arb_state_e        m_state = ARB;
  int                m_cnt = 0;
  int                n_checks = 0;
  int                n_errors = 0;
  logic              s_cpu_gnt, s_ldr_gnt, s_locked, s_cpu_rvalid, s_ldr_rvalid;
  logic [DATA_W-1:0] last_cpu_rd, last_ldr_rd;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [3:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One cycle: sample at negedge, compare against the model, advance the
  // model, then return 1 time unit after the next rising edge.
  task automatic step();
    logic e_cpu, e_ldr;
    logic [DATA_W:0] ent;
    @(negedge clk);
    if (m_state == LOCKED) begin
      e_cpu = 1'b0;
      e_ldr = ldr_req;
    end else begin
      e_ldr = ldr_req && (!cpu_req || (m_cnt == STARVE_MAX));
      e_cpu = cpu_req && !e_ldr;
    end
    s_cpu_gnt = cpu_gnt; s_ldr_gnt = ldr_gnt; s_locked = locked;
    s_cpu_rvalid = cpu_rvalid; s_ldr_rvalid = ldr_rvalid;
    check_eq("cpu_gnt", cpu_gnt, e_cpu);
    check_eq("ldr_gnt", ldr_gnt, e_ldr);
    check_eq("mem_en", mem_en, e_cpu | e_ldr);
    check_eq("locked", locked, m_state == LOCKED);
    if (e_cpu) begin
      check_eq("mem_addr", mem_addr, cpu_addr);
      check_eq("mem_we", mem_we, cpu_we);
      if (cpu_we != 4'h0) check_eq("mem_wdata", mem_wdata, cpu_wdata);
    end else if (e_ldr) begin
      check_eq("mem_addr", mem_addr, ldr_addr);
      check_eq("mem_we", mem_we, ldr_we);
      if (ldr_we != 4'h0) check_eq("mem_wdata", mem_wdata, ldr_wdata);
    end else begin
      check_eq("mem_idle", {mem_we, mem_addr, mem_wdata}, '0);
    end
    // read return
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      check_eq("cpu_rvalid", cpu_rvalid, !ent[DATA_W]);
      check_eq("ldr_rvalid", ldr_rvalid, ent[DATA_W]);
      if (ent[DATA_W]) begin
        check_eq("ldr_rdata", ldr_rdata, ent[DATA_W-1:0]);
        last_ldr_rd = ldr_rdata;
      end else begin
        check_eq("cpu_rdata", cpu_rdata, ent[DATA_W-1:0]);
        last_cpu_rd = cpu_rdata;
      end
    end else begin
      check_eq("no_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    end
    // model update
    if (e_cpu) begin
      if (cpu_we == 4'h0) exp_q.push_back({1'b0, ref_mem[cpu_addr]});
      else ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_wdata, cpu_we);
    end else if (e_ldr) begin
      if (ldr_we == 4'h0) exp_q.push_back({1'b1, ref_mem[ldr_addr]});
      else ref_mem[ldr_addr] = merge(ref_mem[ldr_addr], ldr_wdata, ldr_we);
    end
    if (m_state == LOCKED || e_ldr || !ldr_req) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt++;
    if (m_state == ARB && e_ldr && ldr_lock) m_state = LOCKED;
    else if (m_state == LOCKED && !ldr_lock) m_state = ARB;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic [3:0] we, input int addr, input logic [DATA_W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = ADDR_W'(addr); cpu_wdata = d;
  endtask

  task automatic ldr_drive(input logic req, input logic [3:0] we, input int addr, input logic [DATA_W-1:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = ADDR_W'(addr); ldr_wdata = d;
  endtask

  int ldr_gnt_cyc;
  logic [5:0] cpu_mask;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bmem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    check_eq("rst_outs", {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, locked}, 6'b0);
    #2 rst = 1'b1;
    repeat (2) step();

    // CPU write then read at word 5
    cpu_drive(1, 4'hF, 5, 32'hDEADBEEF); step();
    check_eq("wr5_gnt", s_cpu_gnt, 1'b1);
    cpu_drive(1, 4'h0, 5, 0); step();
    check_eq("rd5_gnt", s_cpu_gnt, 1'b1);
    cpu_drive(0, 4'h0, 0, 0); step();
    check_eq("rd5_rvalid", s_cpu_rvalid, 1'b1);
    check_eq("rd5_ldr_rvalid", s_ldr_rvalid, 1'b0);
    check_eq("rd5_data", last_cpu_rd, 32'hDEADBEEF);

    // byte write into a known word
    cpu_drive(1, 4'hF, 20, 32'h11223344); step();
    cpu_drive(1, 4'b0100, 20, 32'h00AB0000); step();
    cpu_drive(1, 4'h0, 20, 0); step();
    cpu_drive(0, 4'h0, 0, 0); step();
    check_eq("byte_merge", last_cpu_rd, 32'h11AB3344);

    // lock mode: loader writes 0..7, CPU kept waiting
    ldr_lock = 1'b1;
    ldr_drive(1, 4'hF, 0, 32'h1000); step();
    check_eq("lock_first_gnt", s_ldr_gnt, 1'b1);
    cpu_drive(1, 4'h0, 3, 0);
    for (int i = 1; i < 8; i++) begin
      ldr_drive(1, 4'hF, i, 32'h1000 + i); step();
      check_eq("lock_locked", s_locked, 1'b1);
      check_eq("lock_cpu_blocked", s_cpu_gnt, 1'b0);
    end
    ldr_drive(0, 4'h0, 0, 0); ldr_lock = 1'b0; step();
    check_eq("unlock_cycle_locked", s_locked, 1'b1);
    check_eq("unlock_cycle_cpu", s_cpu_gnt, 1'b0);
    step();
    check_eq("unlock_cpu_gnt", s_cpu_gnt, 1'b1);
    cpu_drive(0, 4'h0, 0, 0); step();
    check_eq("unlock_rd3", last_cpu_rd, 32'h1003);

    // alternating reads CPU addr 1, loader addr 2
    cpu_drive(1, 4'h0, 1, 0); step();
    cpu_drive(0, 4'h0, 0, 0); ldr_drive(1, 4'h0, 2, 0); step();
    check_eq("alt_cpu_rvalid", s_cpu_rvalid, 1'b1);
    ldr_drive(0, 4'h0, 0, 0); step();
    check_eq("alt_ldr_rvalid", s_ldr_rvalid, 1'b1);
    check_eq("alt_cpu_data", last_cpu_rd, 32'h1001);
    check_eq("alt_ldr_data", last_ldr_rd, 32'h1002);

    // starvation bound
    ldr_gnt_cyc = -1;
    cpu_mask = '0;
    cpu_drive(1, 4'hF, 10, 32'hC0);
    ldr_drive(1, 4'h0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      cpu_mask[c] = s_cpu_gnt;
      if (s_cpu_gnt) cpu_drive(1, 4'hF, 11 + c, 32'hC1 + c);
      if (s_ldr_gnt && ldr_gnt_cyc < 0) begin
        ldr_gnt_cyc = c;
        ldr_drive(0, 4'h0, 0, 0);
      end
    end
    check_eq("starve_ldr_cycle", ldr_gnt_cyc, 4);
    check_eq("starve_cpu_mask", cpu_mask, 6'b101111);
    cpu_drive(0, 4'h0, 0, 0); step(); step();

    // reset asserted while a read is in flight
    cpu_drive(1, 4'h0, 5, 0);
    @(negedge clk);
    check_eq("rstmid_gnt", cpu_gnt, 1'b1);
    #1 rst = 1'b0;
    cpu_drive(0, 4'h0, 0, 0);
    exp_q.delete();
    m_state = ARB; m_cnt = 0;
    @(posedge clk); #1;
    check_eq("rstmid_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || s_cpu_gnt)
        cpu_drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                  $urandom_range(0, 31), $urandom);
      if (!ldr_req || s_ldr_gnt)
        ldr_drive($urandom_range(0, 2) == 0, ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                  $urandom_range(0, 31), $urandom);
      ldr_lock = (m_state == LOCKED) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      step();
    end
    cpu_drive(0, 4'h0, 0, 0); ldr_drive(0, 4'h0, 0, 0); ldr_lock = 1'b0;
    repeat (3) step();
    check_eq("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
